// File: rtl/uart_frame_packer_if.sv
// Byte-in / frame-out bundle between the UART receiver, the packer and the sorter core.
interface uart_frame_packer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic [7:0]                   byte_data;
  logic                         byte_valid;
  logic [WIDTH*DEPTH-1:0]       frame_data;
  logic                         frame_valid;
  logic                         frame_ready;
  logic [$clog2(DEPTH+1)-1:0]   word_count;
  logic                         overrun;
  logic                         resync;

  // Environment side: byte producer and frame consumer.
  modport master (
    output byte_data,
    output byte_valid,
    output frame_ready,
    input  frame_data,
    input  frame_valid,
    input  word_count,
    input  overrun,
    input  resync
  );

  // Packer side.
  modport slave (
    input  byte_data,
    input  byte_valid,
    input  frame_ready,
    output frame_data,
    output frame_valid,
    output word_count,
    output overrun,
    output resync
  );
endinterface

// File: rtl/uart_frame_packer.sv
// Packs received UART bytes into WIDTH-bit words and DEPTH-word frames,
// with idle-timeout resynchronisation and overrun reporting.
module uart_frame_packer #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 8,
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                clk,
  input logic                rst,
  uart_frame_packer_if.slave bus
);

  localparam int BYTES   = WIDTH / 8;
  localparam int BCW     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WCW     = $clog2(DEPTH + 1);
  localparam int IW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BYTES - 1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(DEPTH - 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(TO_LAST);
  localparam logic [IW-1:0]  IDLE_MAX  = '1;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t                   state_q, state_d;
  logic [BCW-1:0]           byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]           word_cnt_q, word_cnt_d;
  logic [IW-1:0]            idle_cnt_q, idle_cnt_d;
  logic [WIDTH-1:0]         asm_q, asm_d;
  logic [WIDTH*DEPTH-1:0]   frame_q;
  logic                     overrun_q, overrun_d;
  logic                     resync_q, resync_d;
  logic                     word_done;
  logic                     progress;
  logic [WIDTH-1:0]         word_le;
  logic [WIDTH-1:0]         word_be;

  // Candidate assembly values for both byte orders.
  always_comb begin
    word_le = asm_q;
    word_le[8*int'(byte_cnt_q) +: 8] = bus.byte_data;
    word_be = WIDTH'({asm_q, bus.byte_data});
  end

  // Next-state, counters and pulse outputs.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    idle_cnt_d = idle_cnt_q;
    asm_d      = asm_q;
    overrun_d  = 1'b0;
    resync_d   = 1'b0;
    word_done  = 1'b0;
    progress   = (byte_cnt_q != '0) || (word_cnt_q != '0);

    case (state_q)
      COLLECT: begin
        if (bus.byte_valid) begin
          asm_d      = BIG_ENDIAN ? word_be : word_le;
          idle_cnt_d = '0;
          if (byte_cnt_q == BYTE_LAST) begin
            word_done  = 1'b1;
            byte_cnt_d = '0;
            if (word_cnt_q == WORD_LAST) begin
              word_cnt_d = '0;
              state_d    = HOLD;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if ((TIMEOUT_CYCLES > 0) && progress) begin
          // The cycle that would bring the idle count to TIMEOUT_CYCLES is the timeout.
          if (idle_cnt_q >= IDLE_LAST) begin
            byte_cnt_d = '0;
            word_cnt_d = '0;
            idle_cnt_d = '0;
            resync_d   = 1'b1;
          end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end

      HOLD: begin
        idle_cnt_d = '0;
        if (bus.byte_valid) begin
          overrun_d = 1'b1;
        end
        if (bus.frame_ready) begin
          state_d = COLLECT;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= COLLECT;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      idle_cnt_q <= '0;
      asm_q      <= '0;
      overrun_q  <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      asm_q      <= asm_d;
      overrun_q  <= overrun_d;
      resync_q   <= resync_d;
    end
  end

  // Frame slot storage; only written on word completion, so stable in HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
    end else if (word_done) begin
      frame_q[int'(word_cnt_q)*WIDTH +: WIDTH] <= asm_d;
    end
  end

  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = (state_q == HOLD);
  assign bus.word_count  = (state_q == COLLECT) ? word_cnt_q : '0;
  assign bus.overrun     = overrun_q;
  assign bus.resync      = resync_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
module tb_uart_frame_packer;
  localparam int W = 32;
  localparam int D = 8;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_frame_packer_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  uart_frame_packer_if #(.WIDTH(W), .DEPTH(D)) bus1 ();
  uart_frame_packer_if #(.WIDTH(W), .DEPTH(D)) bus2 ();

  uart_frame_packer #(.WIDTH(W), .DEPTH(D), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(100000))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_frame_packer #(.WIDTH(W), .DEPTH(D), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(100000))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  uart_frame_packer #(.WIDTH(W), .DEPTH(D), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(50))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  int wl_a[8] = '{1, 2, 4, 5, 6, 7, 21, 1};
  int wl_d[8] = '{10, 20, 21, 42, 1, 2, 4, 5};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each word is BYTES consecutive bytes, weighted by arrival order.
  function automatic logic [255:0] model_frame(input bq_t b, input bit be);
    logic [255:0] f;
    logic [31:0]  w;
    f = '0;
    for (int k = 0; k < D; k++) begin
      w = '0;
      for (int i = 0; i < 4; i++)
        w = w | (32'(b[4*k+i]) << (be ? 8*(3-i) : 8*i));
      f[k*W +: W] = w;
    end
    return f;
  endfunction

  function automatic bq_t words_le(input int wl[8]);
    bq_t q;
    q = {};
    for (int k = 0; k < 8; k++) begin
      q.push_back(8'(wl[k]));
      q.push_back(8'h00);
      q.push_back(8'h00);
      q.push_back(8'h00);
    end
    return q;
  endfunction

  function automatic bq_t rand_q(input int n);
    bq_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [7:0] b);
    case (d)
      0: begin bus0.byte_data = b; bus0.byte_valid = 1'b1; end
      1: begin bus1.byte_data = b; bus1.byte_valid = 1'b1; end
      default: begin bus2.byte_data = b; bus2.byte_valid = 1'b1; end
    endcase
    tick();
    bus0.byte_valid = 1'b0;
    bus1.byte_valid = 1'b0;
    bus2.byte_valid = 1'b0;
  endtask

  task automatic send_q(input int d, input bq_t q);
    foreach (q[i]) send(d, q[i]);
  endtask

  initial begin
    bq_t          q;
    bq_t          q2;
    logic [255:0] exp_f;

    bus0.byte_valid = 1'b0; bus0.byte_data = '0; bus0.frame_ready = 1'b0;
    bus1.byte_valid = 1'b0; bus1.byte_data = '0; bus1.frame_ready = 1'b0;
    bus2.byte_valid = 1'b0; bus2.byte_data = '0; bus2.frame_ready = 1'b0;

    // Reset state
    rst = 1'b0;
    repeat (3) tick();
    check("rst_fv0",  bus0.frame_valid, 0);
    check("rst_fd0",  bus0.frame_data,  0);
    check("rst_wc0",  bus0.word_count,  0);
    check("rst_ovr0", bus0.overrun,     0);
    check("rst_rsy0", bus0.resync,      0);
    check("rst_fv1",  bus1.frame_valid, 0);
    check("rst_fv2",  bus2.frame_valid, 0);
    rst = 1'b1;
    tick();

    // Little-endian frame of small words, consumer always ready
    bus0.frame_ready = 1'b1;
    q = words_le(wl_a);
    for (int i = 0; i < 32; i++) begin
      send(0, q[i]);
      if (i == 30) check("a_fv_early", bus0.frame_valid, 0);
      if ((i % 4) == 3 && i != 31) check($sformatf("a_wc_%0d", i), bus0.word_count, (i + 1) / 4);
    end
    check("a_fv",    bus0.frame_valid, 1);
    check("a_frame", bus0.frame_data,  model_frame(q, 1'b0));
    check("a_word6", bus0.frame_data[6*W +: W], 21);
    check("a_wc_end", bus0.word_count, 0);
    tick();
    check("a_fv_drop", bus0.frame_valid, 0);

    // Held frame, overrun while held and on the handshake cycle
    bus0.frame_ready = 1'b0;
    q = rand_q(32);
    exp_f = model_frame(q, 1'b0);
    send_q(0, q);
    check("b_fv",    bus0.frame_valid, 1);
    check("b_frame", bus0.frame_data,  exp_f);
    send(0, 8'hAA);
    check("b_ovr",      bus0.overrun,     1);
    check("b_fv_hold",  bus0.frame_valid, 1);
    check("b_fd_hold",  bus0.frame_data,  exp_f);
    tick();
    check("b_ovr_end",  bus0.overrun,     0);
    check("b_fv_hold2", bus0.frame_valid, 1);
    bus0.frame_ready = 1'b1;
    send(0, 8'h55);
    check("b_fv_drop",  bus0.frame_valid, 0);
    check("b_ovr_hs",   bus0.overrun,     1);
    check("b_fd_hs",    bus0.frame_data,  exp_f);
    tick();
    check("b_ovr_hs_end", bus0.overrun,   0);

    // Dropped bytes must not count; then reset mid-frame after 17 bytes
    q = rand_q(17);
    for (int i = 0; i < 17; i++) begin
      send(0, q[i]);
      if (i == 2)  check("c_wc3",  bus0.word_count, 0);
      if (i == 3)  check("c_wc4",  bus0.word_count, 1);
    end
    check("c_wc17", bus0.word_count, 4);
    rst = 1'b0;
    #1;
    check("c_rst_fv", bus0.frame_valid, 0);
    check("c_rst_wc", bus0.word_count,  0);
    check("c_rst_fd", bus0.frame_data,  0);
    tick();
    check("c_rst_fv2", bus0.frame_valid, 0);
    rst = 1'b1;
    tick();
    q = rand_q(32);
    send_q(0, q);
    check("c_fv",    bus0.frame_valid, 1);
    check("c_frame", bus0.frame_data,  model_frame(q, 1'b0));
    tick();

    // Big-endian byte order
    bus1.frame_ready = 1'b1;
    q = rand_q(28);
    q.push_front(8'h78); q.push_front(8'h56); q.push_front(8'h34); q.push_front(8'h12);
    send_q(1, q);
    check("be_fv",    bus1.frame_valid, 1);
    check("be_word0", bus1.frame_data[W-1:0], 32'h12345678);
    check("be_frame", bus1.frame_data,  model_frame(q, 1'b1));
    tick();
    check("be_fv_drop", bus1.frame_valid, 0);

    // Timeout of a partial frame
    bus2.frame_ready = 1'b1;
    send_q(2, rand_q(7));
    check("t_wc_pre", bus2.word_count, 1);
    for (int i = 0; i < 49; i++) begin
      tick();
      check($sformatf("t_rsy_idle%0d", i), bus2.resync, 0);
    end
    check("t_wc_49", bus2.word_count, 1);
    tick();
    check("t_rsy",    bus2.resync,     1);
    check("t_wc_rsy", bus2.word_count, 0);
    tick();
    check("t_rsy_end", bus2.resync, 0);
    q = words_le(wl_d);
    send_q(2, q);
    check("t_fv",    bus2.frame_valid, 1);
    check("t_frame", bus2.frame_data,  model_frame(q, 1'b0));
    tick();
    check("t_fv_drop", bus2.frame_valid, 0);

    // Byte strobe on the timeout cycle wins
    q = rand_q(2);
    send_q(2, q);
    for (int i = 0; i < 49; i++) tick();
    check("e_rsy_49", bus2.resync, 0);
    q2 = rand_q(30);
    send(2, q2[0]);
    check("e_rsy_edge", bus2.resync, 0);
    q.push_back(q2[0]);
    for (int i = 1; i < 30; i++) begin
      send(2, q2[i]);
      q.push_back(q2[i]);
    end
    check("e_fv",    bus2.frame_valid, 1);
    check("e_frame", bus2.frame_data,  model_frame(q, 1'b0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
